// File: rtl/lock_sequence_controller.sv
// Keypad code-lock sequencer: assembles CODE_LEN-digit attempts, checks them against a
// programmable stored code, and runs the unlock window, failure count, lockout and re-program flow.
module lock_sequence_controller #(
  parameter int                            DIGIT_W        = 3,
  parameter int                            CODE_LEN       = 3,
  parameter logic [DIGIT_W*CODE_LEN-1:0]   DEFAULT_CODE   = 9'b011_111_101,
  parameter int                            MAX_FAILS      = 3,
  parameter int                            UNLOCK_CYCLES  = 8,
  parameter int                            LOCKOUT_CYCLES = 16,
  parameter int                            TIMEOUT_CYCLES = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                digit_valid,
  input  logic [DIGIT_W-1:0]                  digit,
  input  logic                                prog_req,
  output logic                                unlocked,
  output logic                                locked_out,
  output logic                                fail_pulse,
  output logic [$clog2(MAX_FAILS+1)-1:0]      fail_count,
  output logic                                prog_active,
  output logic [$clog2(CODE_LEN+1)-1:0]       entry_count
);

  localparam int CODE_W  = DIGIT_W * CODE_LEN;
  localparam int FC_W    = $clog2(MAX_FAILS + 1);
  localparam int EC_W    = $clog2(CODE_LEN + 1);
  localparam int TMR_MAX = (TIMEOUT_CYCLES > UNLOCK_CYCLES)
                         ? ((TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES)
                         : ((UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_PROG     = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [EC_W-1:0]   ec_q, ec_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic              fp_q, fp_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic [CODE_W-1:0] shift_nxt;
  logic [TMR_W-1:0]  tmr_inc;
  logic [EC_W-1:0]   ec_inc;
  logic [FC_W-1:0]   fc_inc;
  logic              last_digit, timeout, fail_last;

  // One shift register serves as both the attempt buffer and the programming shadow.
  assign shift_nxt  = {shift_q[CODE_W-DIGIT_W-1:0], digit};
  assign tmr_inc    = (tmr_q == TMR_W'(TMR_MAX))   ? tmr_q : tmr_q + 1'b1;
  assign ec_inc     = (ec_q  == EC_W'(CODE_LEN))   ? ec_q  : ec_q  + 1'b1;
  assign fc_inc     = (fc_q  == FC_W'(MAX_FAILS))  ? fc_q  : fc_q  + 1'b1;
  assign last_digit = (ec_q  == EC_W'(CODE_LEN - 1));
  assign timeout    = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign fail_last  = ((int'(fc_q) + 1) >= MAX_FAILS);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ec_d    = ec_q;
    fc_d    = fc_q;
    fp_d    = 1'b0;
    shift_d = shift_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        ec_d  = '0;
        if (digit_valid) begin
          shift_d = shift_nxt;
          ec_d    = EC_W'(1);
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (digit_valid) begin
          shift_d = shift_nxt;
          tmr_d   = '0;
          if (last_digit) begin
            ec_d = '0;
            if (shift_nxt == code_q) begin
              fc_d    = '0;
              state_d = S_UNLOCKED;
            end else begin
              fp_d = 1'b1;
              if (fail_last) begin
                fc_d    = FC_W'(MAX_FAILS);
                state_d = S_LOCKOUT;
              end else begin
                fc_d    = fc_inc;
                state_d = S_IDLE;
              end
            end
          end else begin
            ec_d = ec_inc;
          end
        end else if (timeout) begin
          tmr_d   = '0;
          ec_d    = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_UNLOCKED: begin
        if (prog_req) begin
          tmr_d   = '0;
          ec_d    = '0;
          state_d = S_PROG;
        end else if (tmr_q == TMR_W'(UNLOCK_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_PROG: begin
        if (digit_valid) begin
          shift_d = shift_nxt;
          tmr_d   = '0;
          if (last_digit) begin
            ec_d    = '0;
            code_d  = shift_nxt;
            state_d = S_IDLE;
          end else begin
            ec_d = ec_inc;
          end
        end else if (timeout) begin
          tmr_d   = '0;
          ec_d    = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_LOCKOUT: begin
        if (tmr_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
          tmr_d   = '0;
          fc_d    = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      default: begin
        tmr_d   = '0;
        ec_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      ec_q    <= '0;
      fc_q    <= '0;
      fp_q    <= 1'b0;
      shift_q <= '0;
      code_q  <= DEFAULT_CODE;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ec_q    <= ec_d;
      fc_q    <= fc_d;
      fp_q    <= fp_d;
      shift_q <= shift_d;
      code_q  <= code_d;
    end
  end

  assign unlocked    = (state_q == S_UNLOCKED);
  assign locked_out  = (state_q == S_LOCKOUT);
  assign prog_active = (state_q == S_PROG);
  assign fail_pulse  = fp_q;
  assign fail_count  = fc_q;
  assign entry_count = ec_q;

endmodule

// File: tb/tb_lock_sequence_controller.sv
// Scoreboard bench for lock_sequence_controller: directed scenarios plus random traffic,
// checked every cycle against a digit-list reference model of the lock.
module tb_lock_sequence_controller;

  localparam int CODE_LEN  = 3;
  localparam int MAX_FAILS = 3;
  localparam int UNLOCK_N  = 8;
  localparam int LOCKOUT_N = 16;
  localparam int TIMEOUT_N = 32;

  typedef enum int {M_IDLE, M_ENTRY, M_UNLOCKED, M_PROG, M_LOCKOUT} mode_t;

  typedef struct {
    bit unl;
    bit lo;
    bit fp;
    bit pa;
    int fc;
    int ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       digit_valid = 1'b0;
  logic [2:0] digit = 3'd0;
  logic       prog_req = 1'b0;
  logic       unlocked, locked_out, fail_pulse, prog_active;
  logic [1:0] fail_count, entry_count;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  mode_t m_mode;
  int    m_digits[$];
  int    m_code[CODE_LEN];
  int    m_fails, m_left, m_idle;
  bit    m_pulse;

  always #5 clk = ~clk;

  lock_sequence_controller dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit), .prog_req(prog_req),
    .unlocked(unlocked), .locked_out(locked_out), .fail_pulse(fail_pulse),
    .fail_count(fail_count), .prog_active(prog_active), .entry_count(entry_count)
  );

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.unl = (m_mode == M_UNLOCKED);
    e.lo  = (m_mode == M_LOCKOUT);
    e.pa  = (m_mode == M_PROG);
    e.fp  = m_pulse;
    e.fc  = m_fails;
    e.ec  = (m_mode == M_ENTRY || m_mode == M_PROG) ? m_digits.size() : 0;
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_digits.delete();
    m_code[0] = 3; m_code[1] = 7; m_code[2] = 5;
    m_fails = 0; m_left = 0; m_idle = 0; m_pulse = 0;
  endtask

  // One clock edge of the lock as the user experiences it.
  task automatic model_step(bit dv, int d, bit pr);
    bit match;
    m_pulse = 0;
    case (m_mode)
      M_IDLE: if (dv) begin
        m_digits.delete(); m_digits.push_back(d); m_idle = 0; m_mode = M_ENTRY;
      end
      M_ENTRY, M_PROG: begin
        if (dv) begin
          m_digits.push_back(d); m_idle = 0;
          if (m_digits.size() == CODE_LEN) begin
            if (m_mode == M_PROG) begin
              for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_digits[i];
              m_mode = M_IDLE;
            end else begin
              match = 1;
              for (int i = 0; i < CODE_LEN; i++) if (m_digits[i] != m_code[i]) match = 0;
              if (match) begin
                m_fails = 0; m_left = UNLOCK_N; m_mode = M_UNLOCKED;
              end else begin
                m_pulse = 1; m_fails++;
                if (m_fails >= MAX_FAILS) begin m_left = LOCKOUT_N; m_mode = M_LOCKOUT; end
                else m_mode = M_IDLE;
              end
            end
            m_digits.delete();
          end
        end else begin
          m_idle++;
          if (m_idle >= TIMEOUT_N) begin m_digits.delete(); m_mode = M_IDLE; end
        end
      end
      M_UNLOCKED: begin
        if (pr) begin m_digits.delete(); m_idle = 0; m_mode = M_PROG; end
        else begin m_left--; if (m_left == 0) m_mode = M_IDLE; end
      end
      M_LOCKOUT: begin
        m_left--;
        if (m_left == 0) begin m_fails = 0; m_mode = M_IDLE; end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic cyc(bit dv, int d, bit pr);
    @(negedge clk);
    reset = 1'b1; digit_valid = dv; digit = 3'(d); prog_req = pr;
    model_step(dv, d, pr);
    exp_q.push_back(snapshot());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; digit_valid = 1'b0; prog_req = 1'b0;
    #1;
    chk("async_rst_unlocked", int'(unlocked), 0);
    chk("async_rst_locked_out", int'(locked_out), 0);
    chk("async_rst_fail_pulse", int'(fail_pulse), 0);
    chk("async_rst_prog_active", int'(prog_active), 0);
    chk("async_rst_fail_count", int'(fail_count), 0);
    chk("async_rst_entry_count", int'(entry_count), 0);
    model_reset();
    exp_q.push_back(snapshot());
  endtask

  task automatic enter(int a, int b, int c);
    cyc(1, a, 0); cyc(1, b, 0); cyc(1, c, 0);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("unlocked", int'(unlocked), int'(e.unl));
        chk("locked_out", int'(locked_out), int'(e.lo));
        chk("fail_pulse", int'(fail_pulse), int'(e.fp));
        chk("prog_active", int'(prog_active), int'(e.pa));
        chk("fail_count", int'(fail_count), e.fc);
        chk("entry_count", int'(entry_count), e.ec);
      end
    end
  end

  initial begin : stimulus
    int  d;
    bit  dv, pr;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    idle(2);
    // Correct default code unlocks for the full window.
    enter(3, 7, 5); idle(10);
    // Three failures, lockout, ignored correct code, then unlock.
    enter(0, 0, 0); idle(2); enter(0, 0, 0); idle(2); enter(0, 0, 0); idle(3);
    enter(3, 7, 5); idle(16); enter(3, 7, 5); idle(10);
    // Re-program while unlocked.
    enter(3, 7, 5); cyc(0, 0, 1); enter(1, 2, 4); idle(2);
    enter(3, 7, 5); idle(3); enter(1, 2, 4); idle(10);
    // Partial entry times out.
    do_reset(); cyc(1, 3, 0); cyc(1, 7, 0); idle(32); enter(3, 7, 5); idle(10);
    // Digit lands exactly in the expiry cycle after two failures.
    enter(0, 0, 0); idle(2); enter(0, 0, 0); idle(2);
    cyc(1, 3, 0); idle(31); cyc(1, 7, 0); idle(5); cyc(1, 5, 0); idle(10);
    // Reset mid-lockout and mid-programming.
    enter(0, 0, 0); idle(1); enter(0, 0, 0); idle(1); enter(0, 0, 0); idle(5);
    do_reset(); enter(3, 7, 5); idle(10);
    enter(3, 7, 5); cyc(0, 0, 1); cyc(1, 1, 0); cyc(1, 2, 0);
    do_reset(); enter(3, 7, 5); idle(10);
    // Random traffic, biased toward the current code so every state is visited.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 999) < 3) do_reset();
      else if ($urandom_range(0, 199) == 0) idle($urandom_range(28, 36));
      else begin
        dv = ($urandom_range(0, 99) < 45);
        pr = ($urandom_range(0, 99) < 15);
        if ($urandom_range(0, 99) < 70 && m_digits.size() < CODE_LEN) d = m_code[m_digits.size()];
        else d = $urandom_range(0, 7);
        cyc(dv, d, pr);
      end
    end
    idle(2);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
